dff_timing_monitor: RTL and testbench

DFF_TIMING_MONITOR -- requirements
Module: dff_timing_monitor

---
 rtl/dff_timing_monitor.sv | 111 +++++++++++
 tb/tb_dff_timing_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dff_timing_monitor
// Description : Cycle-sampled setup/hold (and, with DFF_RECREM_CHECK_EN,
//               recovery/removal) checker for a monitored flip-flop.
// Revision    : 1.0
// ============================================================================
module dff_timing_monitor #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned REC_CYC   = 2,
  parameter int unsigned REM_CYC   = 2
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       D_mon,
  input  logic       CK_mon,
  input  logic       RN_mon,
  input  logic       clr,
  output logic       NOTIFIER,
  output logic       viol_setup,
  output logic       viol_hold,
  output logic       viol_rec,
  output logic [7:0] viol_count
);

  localparam logic [3:0] AGE_MAX = 4'd15;

  // A saturated age yields gap 16, so thresholds above that would flag every event.
  if (SETUP_CYC > 16 || HOLD_CYC > 16 || REC_CYC > 16 || REM_CYC > 16) begin : g_param_check
    $error("dff_timing_monitor: cycle thresholds above 16 exceed the age range");
  end

  logic       d_q, ck_q, rn_q;
  logic       d_chg, ck_rise;
  logic [3:0] age_d, age_ck;
  logic [4:0] gap_d, gap_ck;
  logic       setup_v, hold_v, rec_v, any_v;

  function automatic logic [3:0] next_age(input logic ev, input logic [3:0] age);
    if (ev)                 return 4'd0;
    else if (age == AGE_MAX) return AGE_MAX;
    else                    return age + 4'd1;
  endfunction

  assign d_chg   = D_mon ^ d_q;
  assign ck_rise = CK_mon & ~ck_q;
  assign gap_d   = d_chg   ? 5'd0 : {1'b0, age_d}  + 5'd1;
  assign gap_ck  = ck_rise ? 5'd0 : {1'b0, age_ck} + 5'd1;

  assign setup_v = ck_rise & rn_q & (32'(gap_d) < SETUP_CYC);
  assign hold_v  = d_chg & ~ck_rise & rn_q & (32'(gap_ck) < HOLD_CYC);
  assign any_v   = setup_v | hold_v | rec_v;

  always_ff @(posedge CK) begin
    d_q  <= D_mon;
    ck_q <= CK_mon;
    rn_q <= RN_mon;
    if (!RN) begin
      age_d  <= AGE_MAX;
      age_ck <= AGE_MAX;
    end else begin
      age_d  <= next_age(d_chg, age_d);
      age_ck <= next_age(ck_rise, age_ck);
    end
  end

`ifdef DFF_RECREM_CHECK_EN
  logic       rn_rise;
  logic [3:0] age_rn;
  logic [4:0] gap_rn;

  assign rn_rise = RN_mon & ~rn_q;
  assign gap_rn  = rn_rise ? 5'd0 : {1'b0, age_rn} + 5'd1;
  assign rec_v   = (ck_rise & (32'(gap_rn) < REC_CYC))
                 | (rn_rise & (32'(gap_ck) < REM_CYC));

  always_ff @(posedge CK) begin
    if (!RN) begin
      age_rn   <= AGE_MAX;
      viol_rec <= 1'b0;
    end else begin
      age_rn   <= next_age(rn_rise, age_rn);
      viol_rec <= (viol_rec & ~clr) | rec_v;
    end
  end
`else
  assign rec_v    = 1'b0;
  assign viol_rec = 1'b0;
`endif

  // A violation in the same cycle as clr survives the clear.
  always_ff @(posedge CK) begin
    if (!RN) begin
      NOTIFIER   <= 1'b0;
      viol_setup <= 1'b0;
      viol_hold  <= 1'b0;
      viol_count <= 8'd0;
    end else begin
      if (any_v) NOTIFIER <= ~NOTIFIER;
      viol_setup <= (viol_setup & ~clr) | setup_v;
      viol_hold  <= (viol_hold & ~clr) | hold_v;
      if (clr)
        viol_count <= {7'd0, any_v};
      else if (any_v && viol_count != 8'hFF)
        viol_count <= viol_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_timing_monitor.sv
`default_nettype none
// Testbench for dff_timing_monitor: directed scenarios plus random stimulus
// checked against an event-timestamp reference model.
module tb_dff_timing_monitor;

  localparam int SETUP_CYC = 2;
  localparam int HOLD_CYC  = 2;
  localparam int REC_CYC   = 2;
  localparam int REM_CYC   = 2;

  logic       CK = 1'b0;
  logic       RN, D_mon, CK_mon, RN_mon, clr;
  logic       NOTIFIER, viol_setup, viol_hold, viol_rec;
  logic [7:0] viol_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: timestamps of last events instead of age counters
  int cyc = 0;
  int last_d, last_ck, last_rn;
  bit m_dq, m_ckq, m_rnq;
  bit m_set, m_hold, m_rec, m_notif;
  int m_cnt;

  dff_timing_monitor #(
    .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .REC_CYC(REC_CYC), .REM_CYC(REM_CYC)
  ) dut (
    .CK(CK), .RN(RN), .D_mon(D_mon), .CK_mon(CK_mon), .RN_mon(RN_mon), .clr(clr),
    .NOTIFIER(NOTIFIER), .viol_setup(viol_setup), .viol_hold(viol_hold),
    .viol_rec(viol_rec), .viol_count(viol_count)
  );

  always #5 CK = ~CK;

  function automatic int gap_of(input bit ev, input int last, input int now);
    if (ev) return 0;
    return (now - last > 16) ? 16 : now - last;
  endfunction

  task automatic tick();
    bit dchg, ckr, sv, hv, rv;
    int gd, gck;
`ifdef DFF_RECREM_CHECK_EN
    bit rnr;
    int grn;
`endif
    if (!RN) begin
      last_d = -100; last_ck = -100; last_rn = -100;
      m_set = 0; m_hold = 0; m_rec = 0; m_notif = 0; m_cnt = 0;
    end else begin
      dchg = (D_mon != m_dq);
      ckr  = CK_mon && !m_ckq;
      gd   = gap_of(dchg, last_d, cyc);
      gck  = gap_of(ckr, last_ck, cyc);
      sv   = ckr && m_rnq && (gd < SETUP_CYC);
      hv   = dchg && !ckr && m_rnq && (gck < HOLD_CYC);
      rv   = 0;
`ifdef DFF_RECREM_CHECK_EN
      rnr  = RN_mon && !m_rnq;
      grn  = gap_of(rnr, last_rn, cyc);
      rv   = (ckr && grn < REC_CYC) || (rnr && gck < REM_CYC);
      if (rnr) last_rn = cyc;
`endif
      if (clr) begin m_set = 0; m_hold = 0; m_rec = 0; m_cnt = 0; end
      m_set  = m_set  | sv;
      m_hold = m_hold | hv;
      m_rec  = m_rec  | rv;
      if (sv || hv || rv) begin
        m_notif = !m_notif;
        if (m_cnt < 255) m_cnt++;
      end
      if (dchg) last_d = cyc;
      if (ckr) last_ck = cyc;
    end
    m_dq = D_mon; m_ckq = CK_mon; m_rnq = RN_mon;
    cyc++;
    @(posedge CK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    RN = 0; D_mon = 0; CK_mon = 0; RN_mon = 1; clr = 0;
    idle(2);
    RN = 1;
    tick();
  endtask

  task automatic test_reset();
    RN = 0; D_mon = 1; CK_mon = 1; RN_mon = 1; clr = 0;
    idle(3);
    n_cmp++; if (NOTIFIER !== 1'b0) begin n_bad++; $display("FAIL reset_notifier got %b want 0", NOTIFIER); end
    n_cmp++; if ({viol_setup, viol_hold, viol_rec} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {viol_setup, viol_hold, viol_rec}); end
    n_cmp++; if (viol_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", viol_count); end
    // pins high through release: simultaneous D/CK "change" must not be seen
    RN = 1;
    tick();
    n_cmp++; if (viol_count !== 8'd0 || viol_setup !== 1'b0) begin n_bad++; $display("FAIL release_no_event got count=%0d setup=%b want 0/0", viol_count, viol_setup); end
  endtask

  task automatic test_setup();
    apply_reset();
    D_mon = 1; tick(); tick();
    CK_mon = 1; tick();                       // D changed 2 cycles earlier: legal
    n_cmp++; if (viol_count !== 8'd0) begin n_bad++; $display("FAIL setup_gap2 got count=%0d want 0", viol_count); end
    CK_mon = 0; tick();
    D_mon = 0; tick();
    CK_mon = 1; tick();                       // D changed 1 cycle earlier
    n_cmp++; if (viol_setup !== 1'b1 || viol_hold !== 1'b0) begin n_bad++; $display("FAIL setup_gap1 got setup=%b hold=%b want 1/0", viol_setup, viol_hold); end
    n_cmp++; if (viol_count !== 8'd1 || NOTIFIER !== 1'b1) begin n_bad++; $display("FAIL setup_gap1_cnt got count=%0d notif=%b want 1/1", viol_count, NOTIFIER); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    D_mon = 1; CK_mon = 1; tick();
    n_cmp++; if ({viol_setup, viol_hold, viol_count} !== {1'b1, 1'b0, 8'd1}) begin n_bad++; $display("FAIL simult got setup=%b hold=%b count=%0d want 1/0/1", viol_setup, viol_hold, viol_count); end
  endtask

  task automatic test_hold();
    apply_reset();
    CK_mon = 1; tick();
    CK_mon = 0; tick();
    tick();
    D_mon = 1; tick();                        // 3 cycles after CK rise
    n_cmp++; if (viol_count !== 8'd0 || viol_hold !== 1'b0) begin n_bad++; $display("FAIL hold_gap3 got count=%0d hold=%b want 0/0", viol_count, viol_hold); end
    idle(2);
    CK_mon = 1; tick();
    D_mon = 0; tick();                        // 1 cycle after CK rise
    n_cmp++; if ({viol_hold, viol_setup, viol_count} !== {1'b1, 1'b0, 8'd1}) begin n_bad++; $display("FAIL hold_gap1 got hold=%b setup=%b count=%0d want 1/0/1", viol_hold, viol_setup, viol_count); end
  endtask

  task automatic test_rnmon_and_saturate();
    int toggles;
    logic prev;
    apply_reset();
    RN_mon = 0; tick();
    D_mon = 1; CK_mon = 1; tick();
    D_mon = 0; CK_mon = 0; tick();
    CK_mon = 1; tick();
    D_mon = 1; tick();
    CK_mon = 0; idle(3);
    n_cmp++; if ({viol_setup, viol_hold, viol_rec, viol_count, NOTIFIER} !== 12'd0) begin n_bad++; $display("FAIL rnmon_suppress got s=%b h=%b r=%b count=%0d notif=%b want all 0", viol_setup, viol_hold, viol_rec, viol_count, NOTIFIER); end
    RN_mon = 1; tick();
    idle(3);
    toggles = 0;
    prev = NOTIFIER;
    for (int i = 0; i < 300; i++) begin
      CK_mon = (i % 2 == 0);
      D_mon  = ~D_mon;
      tick();
      if (NOTIFIER !== prev) toggles++;
      prev = NOTIFIER;
    end
    CK_mon = 0; tick();
    n_cmp++; if (viol_count !== 8'd255) begin n_bad++; $display("FAIL saturate_count got %0d want 255", viol_count); end
    n_cmp++; if (toggles != 300) begin n_bad++; $display("FAIL saturate_toggles got %0d want 300", toggles); end
    n_cmp++; if ({viol_setup, viol_hold, viol_rec} !== 3'b110) begin n_bad++; $display("FAIL saturate_flags got %b want 110", {viol_setup, viol_hold, viol_rec}); end
  endtask

  task automatic test_clr_with_hold();
    apply_reset();
    D_mon = 1; CK_mon = 1; tick();            // setup violation
    CK_mon = 0; idle(3);
    CK_mon = 1; tick();
    D_mon = 0; clr = 1; tick();               // hold violation together with clr
    clr = 0;
    n_cmp++; if ({viol_setup, viol_hold, viol_rec, viol_count} !== {3'b010, 8'd1}) begin n_bad++; $display("FAIL clr_hold got s=%b h=%b r=%b count=%0d want 0/1/0/1", viol_setup, viol_hold, viol_rec, viol_count); end
    n_cmp++; if (NOTIFIER !== 1'b0) begin n_bad++; $display("FAIL clr_hold_notif got %b want 0", NOTIFIER); end
    CK_mon = 0; idle(3);
    clr = 1; tick(); clr = 0;
    n_cmp++; if ({viol_hold, viol_count} !== 9'd0) begin n_bad++; $display("FAIL clr_alone got hold=%b count=%0d want 0/0", viol_hold, viol_count); end
  endtask

  task automatic test_recrem();
    apply_reset();
    RN_mon = 0; idle(4);
    RN_mon = 1; tick();
    CK_mon = 1; tick();                       // CK rise 1 cycle after RN_mon rise
`ifdef DFF_RECREM_CHECK_EN
    n_cmp++; if (viol_rec !== 1'b1 || viol_count !== 8'd1) begin n_bad++; $display("FAIL recovery got rec=%b count=%0d want 1/1", viol_rec, viol_count); end
`else
    n_cmp++; if (viol_rec !== 1'b0 || viol_count !== 8'd0) begin n_bad++; $display("FAIL recovery_off got rec=%b count=%0d want 0/0", viol_rec, viol_count); end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      RN     = ($urandom_range(99) != 0);
      clr    = ($urandom_range(39) == 0);
      if ($urandom_range(2) == 0)  D_mon  = ~D_mon;
      if ($urandom_range(1) == 0)  CK_mon = ~CK_mon;
      if ($urandom_range(9) == 0)  RN_mon = ~RN_mon;
      tick();
      n_cmp++; if (NOTIFIER !== m_notif) begin n_bad++; $display("FAIL rand_notifier cyc=%0d got %b want %b", cyc, NOTIFIER, m_notif); end
      n_cmp++; if (viol_setup !== m_set) begin n_bad++; $display("FAIL rand_setup cyc=%0d got %b want %b", cyc, viol_setup, m_set); end
      n_cmp++; if (viol_hold !== m_hold) begin n_bad++; $display("FAIL rand_hold cyc=%0d got %b want %b", cyc, viol_hold, m_hold); end
      n_cmp++; if (viol_rec !== m_rec) begin n_bad++; $display("FAIL rand_rec cyc=%0d got %b want %b", cyc, viol_rec, m_rec); end
      n_cmp++; if (viol_count !== 8'(m_cnt)) begin n_bad++; $display("FAIL rand_count cyc=%0d got %0d want %0d", cyc, viol_count, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_simultaneous();
    test_hold();
    test_rnmon_and_saturate();
    test_clr_with_hold();
    test_recrem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
